// File: rtl/mii_echo_engine.sv
// rtl/mii_echo_engine.sv - MII frame capture and verbatim echo with regenerated preamble and IFG
module mii_echo_engine #(
  parameter int MAX_BYTES   = 1518,
  parameter int MIN_BYTES   = 64,
  parameter int PRE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rx_data,
  input  logic             rx_dv,
  input  logic             rx_er,
  output logic [3:0]       tx_data,
  output logic             tx_en,
  output logic             busy,
  output logic [CNT_W-1:0] frames_echoed,
  output logic [CNT_W-1:0] frames_dropped
);

  // Buffer address width, byte-count width (must hold MAX_BYTES itself) and TX nibble counter width.
  localparam int AW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int CW  = $clog2(MAX_BYTES + 1);
  localparam int TCW = $clog2(2 * MAX_BYTES + PRE_NIBBLES + IFG_NIBBLES + 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_PRE  = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] R_DROP = 2'd3;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_PRE  = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_IFG  = 2'd3;

  // Registered MII inputs; rx_dv_qq only exists to detect the rising edge of rx_dv.
  logic [3:0]     rx_data_q;
  logic           rx_dv_q;
  logic           rx_dv_qq;
  logic           rx_er_q;

  // Receive side state.
  logic [1:0]     rx_state;
  logic [3:0]     rx_low;
  logic           rx_phase;
  logic           rx_bad;
  logic [CW-1:0]  wr_cnt;

  // Transmit side state.
  logic [1:0]     tx_state;
  logic [TCW-1:0] tx_cnt;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     rd_byte;
  logic [CW-1:0]  len_q;
  logic           tx_start;

  logic [7:0]     mem [0:MAX_BYTES-1];

  // Decoded conditions shared between the always blocks.
  logic           rx_rise;
  logic           in_pre;
  logic           frame_good;
  logic           accept_now;
  logic           mem_we;
  logic           ifg_done;
  logic [TCW-1:0] data_last;
  logic [AW-1:0]  rd_last;

  assign rx_rise    = rx_dv_q && !rx_dv_qq;
  // The nibble on the rise cycle is judged like any other preamble nibble.
  assign in_pre     = ((rx_state == R_PRE) && rx_dv_q) || ((rx_state == R_IDLE) && rx_rise);
  assign frame_good = !rx_bad && !rx_phase && (wr_cnt >= CW'(MIN_BYTES));
  assign accept_now = (rx_state == R_DATA) && !rx_dv_q && frame_good;
  assign mem_we     = (rx_state == R_DATA) && rx_dv_q && rx_phase && (wr_cnt != CW'(MAX_BYTES));
  assign ifg_done   = (tx_state == T_IFG) && (tx_cnt == TCW'(IFG_NIBBLES - 1));
  assign data_last  = TCW'({len_q, 1'b0}) - TCW'(1);
  assign rd_last    = AW'(len_q - 1'b1);

  // Register the PHY inputs once before any decision is made on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q <= 4'h0;
      rx_dv_q   <= 1'b0;
      rx_dv_qq  <= 1'b0;
      rx_er_q   <= 1'b0;
    end else begin
      rx_data_q <= rx_data;
      rx_dv_q   <= rx_dv;
      rx_dv_qq  <= rx_dv_q;
      rx_er_q   <= rx_er;
    end
  end

  // RX FSM: preamble hunt, byte assembly, end-of-frame verdict and drop counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state       <= R_IDLE;
      rx_low         <= 4'h0;
      rx_phase       <= 1'b0;
      rx_bad         <= 1'b0;
      wr_cnt         <= '0;
      frames_dropped <= '0;
    end else begin
      if (in_pre) begin
        if (rx_data_q == 4'h5) begin
          rx_state <= R_PRE;
        end else if (rx_data_q == 4'hD) begin
          // A frame arriving while the previous echo is still in flight must not touch the buffer.
          rx_state <= busy ? R_DROP : R_DATA;
          rx_phase <= 1'b0;
          rx_bad   <= 1'b0;
          wr_cnt   <= '0;
        end else begin
          rx_state <= R_IDLE;
        end
      end else begin
        case (rx_state)
          R_PRE: begin
            rx_state <= R_IDLE;
          end
          R_DATA: begin
            if (!rx_dv_q) begin
              rx_state <= R_IDLE;
              if (!frame_good && (frames_dropped != '1)) begin
                frames_dropped <= frames_dropped + 1'b1;
              end
            end else begin
              if (rx_er_q) begin
                rx_bad <= 1'b1;
              end
              if (!rx_phase) begin
                rx_low   <= rx_data_q;
                rx_phase <= 1'b1;
              end else if (wr_cnt == CW'(MAX_BYTES)) begin
                rx_state <= R_DROP;
              end else begin
                wr_cnt   <= wr_cnt + 1'b1;
                rx_phase <= 1'b0;
              end
            end
          end
          R_DROP: begin
            if (!rx_dv_q) begin
              rx_state <= R_IDLE;
              if (frames_dropped != '1) begin
                frames_dropped <= frames_dropped + 1'b1;
              end
            end
          end
          default: begin
            rx_state <= R_IDLE;
          end
        endcase
      end
    end
  end

  // Frame buffer: byte write from RX, one-cycle registered read for TX (no reset on the array).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cnt[AW-1:0]] <= {rx_data_q, rx_low};
    end
    rd_byte <= mem[rd_addr];
  end

  // Hand-off from RX to TX: latch the accepted length and pulse the TX start one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start <= 1'b0;
      len_q    <= '0;
    end else begin
      tx_start <= accept_now;
      if (accept_now) begin
        len_q <= wr_cnt;
      end
    end
  end

  // busy covers the whole echo, from acceptance to the end of the inter-frame gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (accept_now) begin
      busy <= 1'b1;
    end else if (ifg_done) begin
      busy <= 1'b0;
    end
  end

  // TX FSM: tx_cnt indexes the nibble currently on the pins within the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state      <= T_IDLE;
      tx_cnt        <= '0;
      tx_en         <= 1'b0;
      tx_data       <= 4'h0;
      rd_addr       <= '0;
      frames_echoed <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          rd_addr <= '0;
          if (tx_start) begin
            tx_state <= T_PRE;
            tx_cnt   <= '0;
            tx_en    <= 1'b1;
            tx_data  <= 4'h5;
          end
        end
        T_PRE: begin
          if (tx_cnt == TCW'(PRE_NIBBLES)) begin
            // SFD is on the pins; byte 0 has been waiting in rd_byte since T_IDLE.
            tx_state <= T_DATA;
            tx_cnt   <= '0;
            tx_data  <= rd_byte[3:0];
            if (rd_addr != rd_last) begin
              rd_addr <= rd_addr + 1'b1;
            end
          end else begin
            tx_cnt  <= tx_cnt + 1'b1;
            tx_data <= (tx_cnt == TCW'(PRE_NIBBLES - 1)) ? 4'hD : 4'h5;
          end
        end
        T_DATA: begin
          if (tx_cnt == data_last) begin
            tx_state <= T_IFG;
            tx_cnt   <= '0;
            tx_en    <= 1'b0;
            tx_data  <= 4'h0;
            if (frames_echoed != '1) begin
              frames_echoed <= frames_echoed + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
            if (!tx_cnt[0]) begin
              tx_data <= rd_byte[7:4];
            end else begin
              // Advancing on each low nibble gives the read one spare cycle before it is needed.
              tx_data <= rd_byte[3:0];
              if (rd_addr != rd_last) begin
                rd_addr <= rd_addr + 1'b1;
              end
            end
          end
        end
        T_IFG: begin
          if (ifg_done) begin
            tx_state <= T_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

endmodule
